// File: rtl/framebuf_pkg.sv
// Shared constants and FSM state type for the frame-buffer scanout sequencer.
package framebuf_pkg;
   localparam int FB_ADDR_W     = 13;
   localparam int FB_DATA_W     = 16;
   localparam int FB_BANK_WORDS = 4096;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/framebuf_scanout_fifo.sv
// Synchronous FIFO holding returned pixel words plus their end-of-frame flag.
module framebuf_scanout_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic                   clk_clk,
   input  logic                   rst_reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared too so out_data reads zero straight out of reset.
   always_ff @(posedge clk_clk) begin
      if (rst_reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign count = count_q;
endmodule

// File: rtl/framebuf_scanout.sv
// Scanout sequencer: reads one frame from the display bank and streams it out.
// Optional stall counter output is enabled by defining FRAMEBUF_SCANOUT_STALL_CNT_EN.
module framebuf_scanout
   import framebuf_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_clk,
   input  logic                 rst_reset,
   input  logic                 frame_start,
   input  logic [FB_ADDR_W-1:0] frame_len,
   input  logic                 swap_req,
   output logic                 swap_ack,
   output logic                 disp_bank,
   output logic                 busy,
   output logic                 frame_done,
   output logic [FB_ADDR_W-1:0] mem_address,
   output logic                 mem_chipselect,
   output logic                 mem_clken,
   output logic                 mem_write,
   output logic [1:0]           mem_byteenable,
   input  logic [FB_DATA_W-1:0] mem_readdata,
   output logic [FB_DATA_W-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
`ifdef FRAMEBUF_SCANOUT_STALL_CNT_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);
   // state | meaning
   // IDLE  | waiting for frame_start; pending bank swaps are applied here
   // RUN   | issuing reads while FIFO credit allows
   // DRAIN | all reads issued; waiting for read pipe and FIFO to empty

   localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [FB_ADDR_W-1:0] MAX_LEN = FB_ADDR_W'(FB_BANK_WORDS);
   localparam logic [FB_ADDR_W-1:0] LEN_ONE = 1;

   state_t                 state_q, state_d;
   logic [FB_ADDR_W-1:0]   len_q, len_d;
   logic [FB_ADDR_W-1:0]   idx_q, idx_d;
   logic [FB_ADDR_W-1:0]   addr_q, addr_d;
   logic                   bank_q, bank_d;
   logic                   pend_q, pend_d;
   logic                   swap_ack_q, swap_ack_d;
   logic                   busy_q, busy_d;
   logic                   zdone_q, zdone_d;
   logic                   cs_q, cs_d;
   logic                   lst_q, lst_d;
   logic [RD_LATENCY-1:0]  vld_q, vld_d;
   logic [RD_LATENCY-1:0]  vlast_q, vlast_d;

   logic [CNT_W-1:0]       inflight;
   logic                   credit_ok;
   logic                   fifo_empty, fifo_pop;
   logic [FCNT_W-1:0]      fifo_count;
   logic [FB_DATA_W:0]     fifo_dout;

   framebuf_scanout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FB_DATA_W + 1)
   ) u_fifo (
      .clk_clk   (clk_clk),
      .rst_reset (rst_reset),
      .push      (vld_q[RD_LATENCY-1]),
      .din       ({vlast_q[RD_LATENCY-1], mem_readdata}),
      .pop       (fifo_pop),
      .dout      (fifo_dout),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The read currently on the bus counts against credit, as does every
   // read still in the return pipe, so the FIFO can never overflow.
   always_comb begin
      inflight = CNT_W'(cs_q);
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(vld_q[i]);
      end
      credit_ok = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      bank_d     = bank_q;
      pend_d     = pend_q | swap_req;
      swap_ack_d = 1'b0;
      busy_d     = busy_q;
      zdone_d    = 1'b0;
      cs_d       = 1'b0;
      lst_d      = 1'b0;
      vld_d      = RD_LATENCY'({vld_q, cs_q});
      vlast_d    = RD_LATENCY'({vlast_q, cs_q & lst_q});
      case (state_q)
         IDLE: begin
            if (pend_q || swap_req) begin
               bank_d     = ~bank_q;
               swap_ack_d = 1'b1;
               pend_d     = 1'b0;
            end
            if (frame_start) begin
               len_d = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
               idx_d = '0;
               if (frame_len == '0) begin
                  zdone_d = 1'b1;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (idx_q == len_q) begin
               state_d = DRAIN;
            end else if (credit_ok) begin
               cs_d   = 1'b1;
               lst_d  = (idx_q == (len_q - LEN_ONE));
               addr_d = {bank_q, idx_q[FB_ADDR_W-2:0]};
               idx_d  = idx_q + LEN_ONE;
            end
         end
         DRAIN: begin
            if (fifo_empty && !cs_q && (vld_q == '0)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

`ifdef FRAMEBUF_SCANOUT_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && frame_start) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (rst_reset) stall_q <= '0;
      else           stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

   always_ff @(posedge clk_clk) begin
      if (rst_reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         bank_q     <= 1'b0;
         pend_q     <= 1'b0;
         swap_ack_q <= 1'b0;
         busy_q     <= 1'b0;
         zdone_q    <= 1'b0;
         cs_q       <= 1'b0;
         lst_q      <= 1'b0;
         vld_q      <= '0;
         vlast_q    <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         bank_q     <= bank_d;
         pend_q     <= pend_d;
         swap_ack_q <= swap_ack_d;
         busy_q     <= busy_d;
         zdone_q    <= zdone_d;
         cs_q       <= cs_d;
         lst_q      <= lst_d;
         vld_q      <= vld_d;
         vlast_q    <= vlast_d;
      end
   end

   assign fifo_pop       = out_valid & out_ready;
   assign out_valid      = ~fifo_empty;
   assign out_data       = fifo_dout[FB_DATA_W-1:0];
   assign out_last       = fifo_dout[FB_DATA_W];
   assign frame_done     = (fifo_pop & out_last) | zdone_q;
   assign swap_ack       = swap_ack_q;
   assign disp_bank      = bank_q;
   assign busy           = busy_q;
   assign mem_address    = addr_q;
   assign mem_chipselect = cs_q;
   assign mem_clken      = cs_q;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 2'b11;
endmodule

// File: doc/framebuf_scanout.md
Name: framebuf_scanout

Overview:
- Scanout sequencer for the dual-port 8K x 16 frame buffer. Drives one read-only port of the buffer and streams one frame of 16-bit words to the display datapath over a valid/ready interface.
- The buffer is split into two 4096-word banks; address bit 12 selects the bank. CPU-requested bank swaps are applied only between frames, so the display never tears.

Parameters:
- RD_LATENCY, 1, cycles from an accepted read (chipselect & clken) to valid mem_readdata; legal values 1..3.
- FIFO_DEPTH, 4, output FIFO words; power of 2, at least RD_LATENCY+1.

Ports:
- clk_clk  in  1  single clock for all logic.
- rst_reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; starts a frame scan.
- frame_len  in  13  words per frame; sampled at frame start; 1..4096.
- swap_req  in  1  one-cycle pulse; request to flip the display bank.
- swap_ack  out  1  one-cycle pulse when a swap takes effect.
- disp_bank  out  1  bank currently scanned.
- busy  out  1  high from RUN entry until DRAIN exit.
- frame_done  out  1  one-cycle pulse on the final word handshake.
- mem_address  out  13  {disp_bank, word index}.
- mem_chipselect  out  1  read strobe.
- mem_clken  out  1  memory clock enable.
- mem_write  out  1  held 0.
- mem_byteenable  out  2  held 2'b11.
- mem_readdata  in  16  read data from the buffer.
- out_data  out  16  pixel word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  marks the final word of the frame.

Behaviour:
- Reset values: all outputs 0, except mem_byteenable = 2'b11. FSM = IDLE, swap-pending flag cleared, FIFO emptied.
- Reset mid-frame: the FSM aborts. Read data still in flight is discarded by a valid-shift register that is cleared on reset.
- IDLE state:
  - If swap is pending: toggle disp_bank, pulse swap_ack, clear pending.
  - On frame_start: latch len = min(frame_len, 4096), clear the index, go to RUN.
  - If swap_req and frame_start arrive in the same cycle in IDLE: the swap applies first, and the frame scans the new bank.
- frame_len = 0: frame_start produces a frame_done pulse on the next cycle, issues no reads, and stays in IDLE.
- RUN state:
  - Issue a read (mem_chipselect = mem_clken = 1, address = {disp_bank, idx[11:0]}) when issued < len and (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - Index increments by 1 per issued read. The last index is len-1; there is no wrap into the other bank.
  - With no backpressure, throughput is 1 word per cycle after RD_LATENCY.
- RUN to DRAIN: when issued == len.
- DRAIN state: wait until the FIFO is empty and no reads are in flight, then return to IDLE. busy drops on the same cycle.
- Read return: data arriving RD_LATENCY cycles after issue is pushed into the FIFO. The credit check guarantees the FIFO never overflows.
- Output:
  - out_valid = FIFO not empty.
  - Pop on out_valid & out_ready.
  - out_last is asserted with word len-1. frame_done pulses on that word's handshake.
  - out_data and out_last hold stable while out_valid & !out_ready.
- swap_req while busy: sets pending; the swap applies on the first IDLE cycle. Multiple requests during one frame collapse into one swap.
- frame_start while busy: ignored.

Optional Feature:
- Macro: FRAMEBUF_SCANOUT_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0], which counts cycles with out_valid & !out_ready. It saturates at 0xFFFF, clears on frame start, and holds its value after frame_done.
- Undefined: the port and the counter do not exist.

Decomposition:
- Package framebuf_pkg holds:
  - constants FB_ADDR_W = 13, FB_DATA_W = 16, FB_BANK_WORDS = 4096;
  - the state enum (IDLE, RUN, DRAIN).
- One sub-module: framebuf_scanout_fifo, a synchronous FIFO (FIFO_DEPTH x 17 bits: data plus last flag) with count output.

Test Plan:
- Reset, then frame_start with frame_len = 8 and out_ready held 1 → addresses 0x0000..0x0007 issued on consecutive cycles; 8 words out; out_last on the 8th; one frame_done pulse; busy low afterwards.
- swap_req during a frame of length 16 → disp_bank stays 0 until frame_done, then toggles to 1 with one swap_ack pulse. The next frame reads 0x1000..0x100F.
- out_ready toggled 1/0 every cycle, frame_len = 32 → the FIFO never exceeds FIFO_DEPTH; all 32 words arrive in order, with no duplicates or drops.
- frame_len = 5000 → exactly 4096 words are read, and the address never exceeds 0x0FFF for bank 0. frame_len = 0 → frame_done next cycle, no chipselect.
- rst_reset asserted mid-frame with 2 reads in flight → outputs reach reset values the next cycle; stale data never appears. A new frame then starts cleanly at index 0.
- With FRAMEBUF_SCANOUT_STALL_CNT_EN defined and out_ready held 0 for 10 cycles while valid → stall_cnt = 10.
